// File: rtl/stream_in_fifo.sv
// stream_in_fifo: synchronous first-word-fall-through byte FIFO.
// Buffers a valid/ready source stream, presents the head word on out_data
// one cycle after it is written, and reports occupancy and almost-full.
// Only control state (pointers, level) is reset; the storage array is not.
module stream_in_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int AF_LEVEL   = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [LW-1:0] LVL_ONE   = LW'(1);
    localparam logic [LW-1:0] LVL_ZERO  = LW'(0);
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AF    = LW'(AF_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;

    logic clear_s;
    logic push_s;
    logic pop_s;

    // Status flags derived straight from the registered level so they carry no extra latency.
    always_comb begin
        in_ready    = (level_q != LVL_FULL);
        out_valid   = (level_q != LVL_ZERO);
        almost_full = (level_q >= LVL_AF);
        level       = level_q;
        out_data    = mem_q[rd_ptr_q];
    end

    // Handshake qualification; reset and flush both clear and discard same-cycle traffic.
    always_comb begin
        clear_s = reset | flush;
        push_s  = in_valid & in_ready & ~clear_s;
        pop_s   = out_valid & out_ready & ~clear_s;
    end

    // Next-state for pointers and level; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear_s) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = LVL_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
    end

    // Control state registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= LVL_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array: written only on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_stream_in_fifo.sv
// Directed self-checking bench for stream_in_fifo (DEPTH=4, AF_LEVEL=3).
module tb_stream_in_fifo;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] level;
    logic       almost_full;

    int total;
    int bad;

    stream_in_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (4),
        .AF_LEVEL   (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .level       (level),
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag, input logic [31:0] lvl, input logic [31:0] ov,
                              input logic [31:0] ir, input logic [31:0] af);
        chk({tag, "_level"}, 32'(level), lvl);
        chk({tag, "_out_valid"}, 32'(out_valid), ov);
        chk({tag, "_in_ready"}, 32'(in_ready), ir);
        chk({tag, "_almost_full"}, 32'(almost_full), af);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        chk_status("reset", 32'd0, 32'd0, 32'd1, 32'd0);

        // 1: fill with out_ready low
        in_valid = 1'b1;
        in_data  = 8'h11; tick();
        chk_status("fill1", 32'd1, 32'd1, 32'd1, 32'd0);
        chk("fill1_data", 32'(out_data), 32'h11);
        in_data  = 8'h22; tick();
        chk_status("fill2", 32'd2, 32'd1, 32'd1, 32'd0);
        in_data  = 8'h33; tick();
        chk_status("fill3", 32'd3, 32'd1, 32'd1, 32'd1);
        in_data  = 8'h44; tick();
        chk_status("fill4", 32'd4, 32'd1, 32'd0, 32'd1);
        chk("fill4_data", 32'(out_data), 32'h11);

        // 2: full, push held off, one pop frees a slot
        in_data = 8'h55; tick();
        chk_status("full_hold", 32'd4, 32'd1, 32'd0, 32'd1);
        chk("full_hold_data", 32'(out_data), 32'h11);
        out_ready = 1'b1; tick();
        out_ready = 1'b0;
        chk_status("full_pop", 32'd3, 32'd1, 32'd1, 32'd1);
        chk("full_pop_data", 32'(out_data), 32'h22);
        tick();
        in_valid = 1'b0;
        chk_status("refill", 32'd4, 32'd1, 32'd0, 32'd1);
        out_ready = 1'b1;
        chk("drain0", 32'(out_data), 32'h22); tick();
        chk("drain1", 32'(out_data), 32'h33); tick();
        chk("drain2", 32'(out_data), 32'h44); tick();
        chk("drain3", 32'(out_data), 32'h55); tick();
        out_ready = 1'b0;
        chk_status("drained", 32'd0, 32'd0, 32'd1, 32'd0);

        // 3: single word latency
        in_valid = 1'b1;
        in_data  = 8'hA5; tick();
        in_valid = 1'b0;
        in_data  = 8'hxx;
        chk_status("single", 32'd1, 32'd1, 32'd1, 32'd0);
        chk("single_data", 32'(out_data), 32'hA5);
        out_ready = 1'b1; tick();
        out_ready = 1'b0;
        chk_status("single_pop", 32'd0, 32'd0, 32'd1, 32'd0);

        // 4: steady push+pop at level 2 with pointer wrap
        in_valid = 1'b1;
        in_data  = 8'h00; tick();
        in_data  = 8'h01; tick();
        chk("pp_start_level", 32'(level), 32'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'(i + 2);
            chk($sformatf("pp_data%0d", i), 32'(out_data), 32'(i));
            tick();
            chk($sformatf("pp_level%0d", i), 32'(level), 32'd2);
        end
        out_ready = 1'b0;

        // 5: stall at level 3
        in_data = 8'h12; tick();
        in_valid = 1'b0;
        chk_status("stall_start", 32'd3, 32'd1, 32'd1, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall_data%0d", i), 32'(out_data), 32'h0A);
            chk($sformatf("stall_valid%0d", i), 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1; tick();
        out_ready = 1'b0;
        chk("stall_pop_data", 32'(out_data), 32'h0B);
        chk("stall_pop_level", 32'(level), 32'd2);

        // 6a: flush at level 3 with a push and pop presented
        in_valid = 1'b1;
        in_data  = 8'h13; tick();
        chk("pre_flush_level", 32'(level), 32'd3);
        flush     = 1'b1;
        in_data   = 8'h77;
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk_status("flush", 32'd0, 32'd0, 32'd1, 32'd0);
        tick();
        chk_status("flush_idle", 32'd0, 32'd0, 32'd1, 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h88; tick();
        in_valid = 1'b0;
        chk("post_flush_data", 32'(out_data), 32'h88);
        chk("post_flush_level", 32'(level), 32'd1);

        // 6b: reset at level 3 with a push presented
        in_valid = 1'b1;
        in_data  = 8'h21; tick();
        in_data  = 8'h22; tick();
        chk("pre_reset_level", 32'(level), 32'd3);
        reset     = 1'b1;
        in_data   = 8'h99;
        out_ready = 1'b1;
        tick();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk_status("reset2", 32'd0, 32'd0, 32'd1, 32'd0);
        in_valid = 1'b1;
        in_data  = 8'hC3; tick();
        in_valid = 1'b0;
        chk("post_reset_data", 32'(out_data), 32'hC3);
        chk("post_reset_level", 32'(level), 32'd1);

        // reset and flush together behave as reset
        in_valid = 1'b1;
        in_data  = 8'hD4; tick();
        reset    = 1'b1;
        flush    = 1'b1;
        tick();
        reset    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_status("reset_flush", 32'd0, 32'd0, 32'd1, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
